loong_mmio_slice: RTL and testbench



---
 rtl/loong_mmio_slice_pkg.sv | 30 +++
 rtl/loong_bus_watchdog.sv | 31 +++
 rtl/loong_mmio_slice.sv | 116 +++++++++++
 tb/tb_loong_mmio_slice.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/loong_mmio_slice_pkg.sv
// Shared definitions for the MMIO leg of the high mapper: slice state encoding,
// request payload, timeout read value and MMIO address base.
package loong_mmio_slice_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WEB_W  = 4;

    localparam logic [DATA_W-1:0] TIMEOUT_DATA_DEFAULT = 32'hDEAD_BEEF;
    localparam logic [ADDR_W-1:0] MMIO_BASE            = 32'h1000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } slice_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [WEB_W-1:0]  web;
        logic              rd;
    } mmio_req_t;

    // A request is any read strobe or any nonzero byte enable.
    function automatic logic is_req(input logic rd, input logic [WEB_W-1:0] web);
        return rd | (|web);
    endfunction

endpackage

// File: rtl/loong_bus_watchdog.sv
// Saturating wait counter: cleared on start, counts while run, flags expiry at TIMEOUT-1.
module loong_bus_watchdog #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic run,
    output logic expire
);

    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic ENABLED = (TIMEOUT != 0);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (run && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expire = ENABLED && run && (cnt == CNT_LAST);

endmodule

// File: rtl/loong_mmio_slice.sv
// Registered MMIO request slice: holds each access toward the devices until
// dev_ready, or force-completes it with TIMEOUT_DATA when the watchdog expires.
module loong_mmio_slice
    import loong_mmio_slice_pkg::*;
#(
    parameter int unsigned       TIMEOUT      = 1024,
    parameter logic [DATA_W-1:0] TIMEOUT_DATA = TIMEOUT_DATA_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] a,
    input  logic [DATA_W-1:0] d,
    input  logic [WEB_W-1:0]  web,
    input  logic              rd,
    output logic [DATA_W-1:0] spo,
    output logic              ready,
    output logic [ADDR_W-1:0] dev_a,
    output logic [DATA_W-1:0] dev_d,
    output logic [WEB_W-1:0]  dev_web,
    output logic              dev_rd,
    input  logic [DATA_W-1:0] dev_spo,
    input  logic              dev_ready,
    output logic              timeout_flag,
    output logic [ADDR_W-1:0] timeout_addr,
    input  logic              timeout_clr
);

    slice_state_t      state;
    mmio_req_t         dev_q;
    logic [DATA_W-1:0] resp_q;
    logic              req;
    logic              wd_start;
    logic              wd_run;
    logic              wd_expire;

    assign req      = is_req(rd, web);
    assign wd_start = (state == ST_IDLE) && req;
    assign wd_run   = (state == ST_BUSY);

    loong_bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .start  (wd_start),
        .run    (wd_run),
        .expire (wd_expire)
    );

    // Slice FSM; dev_ready takes priority over a same-cycle watchdog expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            dev_q        <= '0;
            resp_q       <= '0;
            timeout_flag <= 1'b0;
            timeout_addr <= '0;
        end else begin
            if (timeout_clr) begin
                timeout_flag <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        dev_q.a   <= a;
                        dev_q.d   <= d;
                        dev_q.web <= web;
                        dev_q.rd  <= rd;
                        state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (dev_ready) begin
                        resp_q    <= dev_spo;
                        dev_q.web <= '0;
                        dev_q.rd  <= 1'b0;
                        state     <= ST_RESP;
                    end else if (wd_expire) begin
                        resp_q       <= TIMEOUT_DATA;
                        dev_q.web    <= '0;
                        dev_q.rd     <= 1'b0;
                        timeout_flag <= 1'b1;
                        timeout_addr <= dev_q.a;
                        state        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Upstream handshake: idle slice reports ready until a request appears.
    always_comb begin
        ready = 1'b0;
        spo   = '0;
        case (state)
            ST_IDLE: ready = ~req;
            ST_RESP: begin
                ready = 1'b1;
                spo   = resp_q;
            end
            default: ready = 1'b0;
        endcase
    end

    assign dev_a   = dev_q.a;
    assign dev_d   = dev_q.d;
    assign dev_web = dev_q.web;
    assign dev_rd  = dev_q.rd;

endmodule

// File: tb/tb_loong_mmio_slice.sv
// Scoreboard bench for loong_mmio_slice with a 16-cycle watchdog.
module tb_loong_mmio_slice;

    localparam int TO = 16;
    localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, d, spo, dev_a, dev_d, dev_spo, timeout_addr;
    logic [3:0]  web, dev_web;
    logic        rd, ready, dev_rd, dev_ready, timeout_flag, timeout_clr;

    typedef struct {
        logic [31:0] spo;
        int          lat;
        bit          to;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   rd_edges = 0;
    logic dev_rd_prev = 1'b0;
    logic exp_flag = 1'b0;
    bit   clr_hold = 1'b0;

    always #5 clk = ~clk;

    loong_mmio_slice #(
        .TIMEOUT      (TO),
        .TIMEOUT_DATA (TO_DATA)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .a            (a),
        .d            (d),
        .web          (web),
        .rd           (rd),
        .spo          (spo),
        .ready        (ready),
        .dev_a        (dev_a),
        .dev_d        (dev_d),
        .dev_web      (dev_web),
        .dev_rd       (dev_rd),
        .dev_spo      (dev_spo),
        .dev_ready    (dev_ready),
        .timeout_flag (timeout_flag),
        .timeout_addr (timeout_addr),
        .timeout_clr  (timeout_clr)
    );

    always @(negedge clk) begin
        if (dev_rd && !dev_rd_prev) rd_edges++;
        dev_rd_prev = dev_rd;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One upstream access; wait_n = cycles after cycle 1 before dev_ready, <0 = never.
    task automatic access(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] w, input logic r,
                          input int wait_n, input logic [31:0] dspo);
        exp_t e, x;
        int   cyc;
        bit   done;
        int   held_err;
        e.to  = (wait_n < 0) || (wait_n >= TO);
        e.spo = e.to ? TO_DATA : dspo;
        e.lat = e.to ? TO + 1 : wait_n + 2;
        sb.push_back(e);
        a = addr; d = data; web = w; rd = r; dev_spo = dspo; dev_ready = 1'b0;
        cyc = 0; done = 0; held_err = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            if (ready && cyc > 0) begin
                x = sb.pop_front();
                if (x.to) exp_flag = 1'b1;
                check_eq("spo", spo, x.spo);
                check_eq("latency", cyc, x.lat);
                check_eq("strobes_dropped", 32'({dev_web, dev_rd}), 32'd0);
                check_eq("dev_a_kept", dev_a, addr);
                check_eq("dev_d_kept", dev_d, data);
                check_eq("timeout_flag", 32'(timeout_flag), 32'(exp_flag));
                if (x.to) check_eq("timeout_addr", timeout_addr, addr);
                done = 1;
            end else if (cyc == 0) begin
                check_eq("ready_low_on_req", 32'(ready), 32'd0);
            end else begin
                if ({dev_a, dev_d, dev_web, dev_rd} !== {addr, data, w, r}) held_err++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (!done) dev_ready = (wait_n >= 0) && (cyc == wait_n + 1);
        end
        if (!done) check_eq("ready_seen", 32'(ready), 32'd1);
        check_eq("dev_held", held_err, 0);
        rd = 1'b0; web = '0; dev_ready = 1'b0;
        if (clr_hold) exp_flag = 1'b0;
    endtask

    initial begin
        int e0;
        rst = 1'b1; a = '0; d = '0; web = '0; rd = 1'b0;
        dev_spo = '0; dev_ready = 1'b0; timeout_clr = 1'b0;
        #12;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", 32'(ready), 32'd1);
        check_eq("rst_spo", spo, 32'd0);
        check_eq("rst_dev_a", dev_a, 32'd0);
        check_eq("rst_strobes", 32'({dev_web, dev_rd}), 32'd0);
        check_eq("rst_flag", 32'(timeout_flag), 32'd0);
        check_eq("rst_taddr", timeout_addr, 32'd0);
        @(posedge clk); #1;

        // Minimum-latency read, then a waited write.
        access(32'h1000_0004, 32'h0, 4'b0000, 1'b1, 0, 32'h1234_5678);
        access(32'h1000_0010, 32'hA5A5_0001, 4'b0011, 1'b0, 5, 32'h0BAD_F00D);

        // Hung read, then clear the sticky flag.
        access(32'h1000_0020, 32'h0, 4'b0000, 1'b1, -1, 32'h7777_7777);
        timeout_clr = 1'b1;
        @(posedge clk); #1;
        timeout_clr = 1'b0;
        exp_flag = 1'b0;
        @(negedge clk);
        check_eq("flag_cleared", 32'(timeout_flag), 32'd0);
        check_eq("taddr_kept", timeout_addr, 32'h1000_0020);
        @(posedge clk); #1;

        // dev_ready on the expiry cycle wins.
        access(32'h1000_0024, 32'h0, 4'b0000, 1'b1, TO - 1, 32'hCAFE_0001);

        // Three back-to-back reads.
        e0 = rd_edges;
        access(32'h1000_0100, 32'h0, 4'b0000, 1'b1, 0, 32'h0000_0A01);
        access(32'h1000_0104, 32'h0, 4'b0000, 1'b1, 1, 32'h0000_0A02);
        access(32'h1000_0108, 32'h0, 4'b0000, 1'b1, 2, 32'h0000_0A03);
        @(negedge clk);
        check_eq("dev_rd_edges", rd_edges - e0, 3);
        @(posedge clk); #1;

        // Clear held through a timed-out write: set wins in the expiry cycle.
        clr_hold = 1'b1; timeout_clr = 1'b1;
        access(32'h1000_0030, 32'h1111_2222, 4'b1111, 1'b0, -1, 32'h0);
        clr_hold = 1'b0; timeout_clr = 1'b0;
        @(negedge clk);
        check_eq("flag_after_hold_clr", 32'(timeout_flag), 32'd0);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a busy read.
        a = 32'h1000_0040; rd = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("busy_dev_rd", 32'(dev_rd), 32'd1);
        #2;
        rst = 1'b1; rd = 1'b0;
        #1;
        check_eq("arst_dev_rd", 32'(dev_rd), 32'd0);
        check_eq("arst_ready", 32'(ready), 32'd1);
        check_eq("arst_dev_a", dev_a, 32'd0);
        check_eq("arst_taddr", timeout_addr, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        access(32'h1000_0044, 32'h0, 4'b0000, 1'b1, 1, 32'h5555_AAAA);
        check_eq("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
